// File: rtl/core_pkg.sv
// Shared types for the Selen core front end.
//   fetch_state_e : fetch sequencer state (FETCH, DISCARD)
//   RESET_PC_DEF  : default reset PC
//   fetch_entry_t : instruction buffer entry {inst, pc, pc_4}, 96 bits
package core_pkg;

    typedef enum logic [0:0] {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc_4;
    } fetch_entry_t;

endpackage

// File: rtl/core_fetch_buf.sv
// Synchronous instruction buffer for the fetch stage.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   flush       : empty the buffer this cycle (wins over push/pop)
//   push        : write push_entry at the tail (ignored when full)
//   push_entry  : entry to write
//   pop         : advance the head (ignored when empty)
//   count       : number of valid entries
//   head        : head entry, all zeros when empty
//   empty       : no valid entries
module core_fetch_buf
    import core_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_entry,
    input  logic          pop,
    output logic [CW-1:0] count,
    output fetch_entry_t  head,
    output logic          empty
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push_ok && !rst && !flush) mem_q[wr_ptr] <= push_entry;
    end

    assign head = empty ? '0 : mem_q[rd_ptr];

endmodule

// File: rtl/core_fetch_s.sv
// Instruction-fetch stage: holds the PC, requests words from IL1, buffers
// returned instructions with their PC and PC+4, and presents the head entry
// to decode. Redirects flush the buffer and drop any in-flight response.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   fetch_il1_req/addr             : word request to IL1
//   fetch_il1_ack/data             : IL1 response (data valid with ack)
//   fetch_redirect/_pc             : redirect strobe and target from execute
//   fetch_dec_enb                  : decode consumes the head entry
//   fetch_valid/inst/pc/pc_4       : head entry to decode
//   fetch_nop_gen                  : ~fetch_valid, for decode nop generation
module core_fetch_s
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        fetch_il1_req,
    output logic [31:0] fetch_il1_addr,
    input  logic        fetch_il1_ack,
    input  logic [31:0] fetch_il1_data,
    input  logic        fetch_redirect,
    input  logic [31:0] fetch_redirect_pc,
    input  logic        fetch_dec_enb,
    output logic        fetch_valid,
    output logic [31:0] fetch_inst,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_pc_4,
    output logic        fetch_nop_gen
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [31:0] RST_PC = {RESET_PC[31:2], 2'b00};

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   tgt_q, tgt_d;
    logic          run_q;
    logic [31:0]   redir_tgt;
    logic          ack_ok;
    logic          push;
    logic          pop;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;
    logic [CW-1:0] buf_count;
    logic          buf_empty;
    logic          unused_bits;

    assign unused_bits = ^fetch_redirect_pc[1:0];
    assign redir_tgt   = {fetch_redirect_pc[31:2], 2'b00};

    // run_q keeps req low for the first cycle after reset so a late ack
    // from a request withdrawn by reset cannot be taken as a new response.
    // Once high, req can only fall on an ack: only acks fill the buffer.
    assign fetch_il1_req  = run_q & ((state_q == DISCARD) | (buf_count < CW'(BUF_DEPTH)));
    assign fetch_il1_addr = pc_q;    // pc is held in DISCARD, target lives in tgt
    assign ack_ok         = fetch_il1_ack & fetch_il1_req;

    assign push_entry = '{inst: fetch_il1_data, pc: pc_q, pc_4: pc_q + 32'd4};
    assign pop        = fetch_dec_enb & ~buf_empty & ~fetch_redirect;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        push    = 1'b0;
        case (state_q)
            FETCH: begin
                if (fetch_redirect) begin
                    if (fetch_il1_req && !ack_ok) begin
                        state_d = DISCARD;
                        tgt_d   = redir_tgt;
                    end else begin
                        pc_d = redir_tgt;
                    end
                end else if (ack_ok) begin
                    push = 1'b1;
                    pc_d = pc_q + 32'd4;
                end
            end
            DISCARD: begin
                if (ack_ok) begin
                    pc_d    = fetch_redirect ? redir_tgt : tgt_q;
                    state_d = FETCH;
                end else if (fetch_redirect) begin
                    tgt_d = redir_tgt;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RST_PC;
            tgt_q   <= RST_PC;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            run_q   <= 1'b1;
        end
    end

    core_fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (fetch_redirect),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .count      (buf_count),
        .head       (head),
        .empty      (buf_empty)
    );

    assign fetch_valid   = ~buf_empty;
    assign fetch_nop_gen = buf_empty;
    assign fetch_inst    = head.inst;
    assign fetch_pc      = head.pc;
    assign fetch_pc_4    = head.pc_4;

endmodule
